ir_fetch_decode: RTL
====================

Name: ir_fetch_decode

Overview:
- Instruction-fetch and decode front end for the multicycle core.
- When the control FSM asks for a fetch (its IR-write strobe), this block reads one word from instruction memory over a req/ack handshake and latches it into IR.
- It decodes IR into the one-hot command vector and the instruction fields the FSM consumes, then raises ir_valid (the FSM's W_IR_valid) and holds it until the next fetch request.

Parameters:
ADDR_W, 32, instruction address width
CMD_W, 64, command vector width; bit index equals command code
TIMEOUT, 255, max cycles waiting for imem_ack before fetch_err

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
fetch_req  in  1  fetch strobe from control FSM (IR-write)
fetch_addr  in  ADDR_W  PC value to fetch; sampled with fetch_req
flush  in  1  abort in-flight fetch, drop ir_valid
flags  in  4  current NZCV
imem_req  out  1  memory read request
imem_addr  out  ADDR_W  memory read address
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  read data
ir  out  32  latched instruction
ir_valid  out  1  IR and decoded fields valid (W_IR_valid)
command  out  CMD_W  one-hot command: 0 DP, 1 BX, 2 B, 3 BL, 4 LDR0, 5 LDR1, 6 STR0, 7 STR1, 8 SWP; others 0
rm_imm_s  out  1  ir[25]
rs_imm_s  out  2  00 shift imm5, 01 shift by Rs, 10 rotate imm8 by 2*rot
shift_op  out  3  ir[25] ? 3'b111 : {ir[6:5],ir[4]}
alu_op  out  4  ir[24:21]
s_bit, p_bit, u_bit, w_bit  out  1 each  ir[20], ir[24], ir[23], ir[21]
v_type  out  2  ir[6:5]
ttcc  out  1  1 = condition ir[31:28] fails against flags (combinational on live flags)
undef  out  1  ir_valid and no command bit set
fetch_err  out  1  sticky; set on timeout, cleared by rst or next accepted fetch_req

Behaviour:
- Reset (sync): state IDLE; imem_req=0, imem_addr=0, ir=0, ir_valid=0, command=0, all fields 0, fetch_err=0, timeout counter=0.
- States:
  - IDLE: fetch_req -> REQ.
  - REQ: imem_ack -> HOLD; counter reaches TIMEOUT -> IDLE with fetch_err=1.
  - HOLD: fetch_req -> REQ.
- Accepting fetch_req (IDLE or HOLD) at edge k: imem_addr<=fetch_addr, imem_req<=1, ir_valid<=0, counter<=0, fetch_err<=0.
- fetch_req while in REQ is ignored; the address is not updated.
- imem_req stays high and imem_addr stable until ack.
- At the edge sampling imem_ack=1 in REQ: ir<=imem_rdata; command and fields registered from imem_rdata in the same edge; imem_req<=0; ir_valid<=1.
- Minimum latency: fetch_req edge k, ack at k+1, ir_valid high after edge k+1.
- ir_valid stays high through HOLD; command and fields stay stable until the next ack.
- imem_ack outside REQ is ignored.
- flush (priority over fetch_req and imem_ack): -> IDLE, imem_req=0, ir_valid=0; ir and fields retain their values.
- Decode, in priority order (all others -> command=0, undef=1):
  - BX: ir[27:4]==24'h12FFF1.
  - SWP: ir[27:23]==5'b00010, ir[21:20]==00, ir[11:4]==8'h09.
  - DP: ir[27:26]==00, excluding ir[25]==0 & ir[7]==1 & ir[4]==1 (mul/extension space = undef).
  - B: ir[27:24]==1010. BL: ir[27:24]==1011.
  - ir[27:26]==01 -> L=ir[20], I=ir[25]: LDR0 L&!I, LDR1 L&I, STR0 !L&!I, STR1 !L&I.
- Exactly one command bit set when decode succeeds.
- ttcc uses standard condition codes EQ..AL. Code 1111 is treated as fail (ttcc=1).

Test Plan:
- Reset, then fetch_req with fetch_addr=0x10, imem_ack next cycle with rdata 0xE0821003 -> imem_addr=0x10; command[0]=1; alu_op=0100; s_bit=0; rm_imm_s=0; ttcc=0; ir_valid high after 2 edges.
- Sequence of opcodes, each with ack delayed by 3 cycles -> imem_req held 3 cycles; one-hot command per opcode:
  - 0xEA000004 -> bit2
  - 0xEB000010 -> bit3
  - 0xE12FFF1E -> bit1
  - 0xE1020091 -> bit8
- 0xE5910004 -> command[4], p=1, u=1, w=0. 0xE6810002 -> command[7], p=0, rm_imm_s=1, v_type=00.
- 0x00821003 with flags Z=0 -> ttcc=1; change flags to Z=1 with no refetch -> ttcc=0 the same cycle.
- No ack for TIMEOUT cycles -> fetch_err=1, state IDLE, ir_valid=0. Next fetch_req clears fetch_err.
- flush asserted in the same cycle as imem_ack -> ir unchanged, ir_valid=0. 0xE0000090 (MUL) -> undef=1, command=0.

Source files
------------

// File: rtl/ir_fetch_decode_if.sv
// Bundle between the fetch/decode front end, the control FSM and instruction memory.
// The master modport is the front end's view. The slave modport is the environment's view (FSM + imem).
interface ir_fetch_decode_if #(
  parameter int ADDR_W = 32,
  parameter int CMD_W  = 64
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              flush;
  logic [3:0]        flags;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       ir;
  logic              ir_valid;
  logic [CMD_W-1:0]  command;
  logic              rm_imm_s;
  logic [1:0]        rs_imm_s;
  logic [2:0]        shift_op;
  logic [3:0]        alu_op;
  logic              s_bit;
  logic              p_bit;
  logic              u_bit;
  logic              w_bit;
  logic [1:0]        v_type;
  logic              ttcc;
  logic              undef;
  logic              fetch_err;

  modport master (
    input  fetch_req, fetch_addr, flush, flags, imem_ack, imem_rdata,
    output imem_req, imem_addr, ir, ir_valid, command, rm_imm_s, rs_imm_s,
           shift_op, alu_op, s_bit, p_bit, u_bit, w_bit, v_type, ttcc, undef,
           fetch_err
  );

  modport slave (
    output fetch_req, fetch_addr, flush, flags, imem_ack, imem_rdata,
    input  imem_req, imem_addr, ir, ir_valid, command, rm_imm_s, rs_imm_s,
           shift_op, alu_op, s_bit, p_bit, u_bit, w_bit, v_type, ttcc, undef,
           fetch_err
  );
endinterface

// File: rtl/ir_fetch_decode.sv
// Instruction fetch/decode front end. It fetches one word over the imem req/ack handshake on a fetch strobe.
// IR and the decoded fields are registered on ack. ttcc and undef are combinational on the held IR.
module ir_fetch_decode #(
  parameter int ADDR_W  = 32,
  parameter int CMD_W   = 64,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  ir_fetch_decode_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  typedef struct packed {
    logic       rm_imm_s;
    logic [1:0] rs_imm_s;
    logic [2:0] shift_op;
    logic [3:0] alu_op;
    logic       s_bit;
    logic       p_bit;
    logic       u_bit;
    logic       w_bit;
    logic [1:0] v_type;
  } fields_t;

  state_t            state_q;
  logic              imem_req_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       ir_q;
  logic              ir_valid_q;
  logic [CMD_W-1:0]  cmd_q;
  fields_t           fields_q;
  logic              fetch_err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CMD_W-1:0]  cmd_d;
  fields_t           fields_d;

  function automatic logic [CMD_W-1:0] decode(input logic [31:0] w);
    logic [CMD_W-1:0] c;
    c = '0;
    if (w[27:4] == 24'h12FFF1) begin
      c[1] = 1'b1;
    end else if (w[27:23] == 5'b00010 && w[21:20] == 2'b00 && w[11:4] == 8'h09) begin
      c[8] = 1'b1;
    end else if (w[27:26] == 2'b00) begin
      // Register-form with bit7 and bit4 set is the multiply/extension space: leave undecoded.
      if (!(!w[25] && w[7] && w[4])) c[0] = 1'b1;
    end else if (w[27:24] == 4'b1010) begin
      c[2] = 1'b1;
    end else if (w[27:24] == 4'b1011) begin
      c[3] = 1'b1;
    end else if (w[27:26] == 2'b01) begin
      case ({w[20], w[25]})
        2'b10:   c[4] = 1'b1;
        2'b11:   c[5] = 1'b1;
        2'b00:   c[6] = 1'b1;
        default: c[7] = 1'b1;
      endcase
    end
    return c;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (cc)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cy;
      4'h3:    return !cy;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cy && !z;
      4'h9:    return !cy || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    cmd_d             = decode(bus.imem_rdata);
    fields_d          = '0;
    fields_d.rm_imm_s = bus.imem_rdata[25];
    fields_d.rs_imm_s = bus.imem_rdata[25] ? 2'b10 : {1'b0, bus.imem_rdata[4]};
    fields_d.shift_op = bus.imem_rdata[25] ? 3'b111 : {bus.imem_rdata[6:5], bus.imem_rdata[4]};
    fields_d.alu_op   = bus.imem_rdata[24:21];
    fields_d.s_bit    = bus.imem_rdata[20];
    fields_d.p_bit    = bus.imem_rdata[24];
    fields_d.u_bit    = bus.imem_rdata[23];
    fields_d.w_bit    = bus.imem_rdata[21];
    fields_d.v_type   = bus.imem_rdata[6:5];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      cmd_q       <= '0;
      fields_q    <= '0;
      fetch_err_q <= 1'b0;
      cnt_q       <= '0;
    end else if (bus.flush) begin
      state_q    <= IDLE;
      imem_req_q <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (bus.fetch_req) begin
            state_q     <= REQ;
            imem_addr_q <= bus.fetch_addr;
            imem_req_q  <= 1'b1;
            ir_valid_q  <= 1'b0;
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            state_q    <= HOLD;
            ir_q       <= bus.imem_rdata;
            cmd_q      <= cmd_d;
            fields_q   <= fields_d;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Request has been outstanding for TIMEOUT cycles: give up.
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.command   = cmd_q;
  assign bus.rm_imm_s  = fields_q.rm_imm_s;
  assign bus.rs_imm_s  = fields_q.rs_imm_s;
  assign bus.shift_op  = fields_q.shift_op;
  assign bus.alu_op    = fields_q.alu_op;
  assign bus.s_bit     = fields_q.s_bit;
  assign bus.p_bit     = fields_q.p_bit;
  assign bus.u_bit     = fields_q.u_bit;
  assign bus.w_bit     = fields_q.w_bit;
  assign bus.v_type    = fields_q.v_type;
  assign bus.fetch_err = fetch_err_q;
  assign bus.undef     = ir_valid_q && (cmd_q == '0);
  assign bus.ttcc      = !cond_pass(ir_q[31:28], bus.flags);
endmodule
